// File: rtl/ctrl_pkg.sv
// Shared definitions for the registered RV32 control decoder: opcode
// constants, ALU / branch / instruction-type codes, and the bundle layout
// that travels down the pipe next to each instruction word.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_AND    = 5'd0,
    ALU_OR     = 5'd1,
    ALU_ADD    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SUB    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_XOR    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_SLTU   = 5'd10,
    ALU_PASSB  = 5'd11,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b010,
    BR_BGE  = 3'b011,
    BR_BLTU = 3'b100,
    BR_BGEU = 3'b101
  } br_op_e;

  typedef enum logic [2:0] {
    IT_R   = 3'b000,
    IT_U   = 3'b001,
    IT_J   = 3'b010,
    IT_I   = 3'b011,
    IT_S   = 3'b100,
    IT_B   = 3'b101,
    IT_ILL = 3'b111
  } inst_type_e;

  typedef struct packed {
    alu_op_e    alu_ctrl;
    logic       shamt_en;
    br_op_e     branch_ctrl;
    logic       jump_ctrl;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    inst_type_e inst_type;
    logic       illegal;
  } ctrl_bundle_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_bundle_t);

  // One pipeline slot: the word and the controls decoded from it.
  typedef struct packed {
    logic [31:0]  instr;
    ctrl_bundle_t ctrl;
  } pipe_entry_t;

  // ALU op shared by the register and immediate ALU forms, keyed by funct3.
  function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Bundle for an unsupported word: every control quiet, only the flag set.
  function automatic ctrl_bundle_t illegal_bundle();
    ctrl_bundle_t b;
    b           = '0;
    b.inst_type = IT_ILL;
    b.illegal   = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Instruction-in / control-bundle-out handshake of the decoder.
// master: the decoder side; slave: the IFU/execute environment around it.
interface ctrl_decode_pipe_if;
  import ctrl_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  alu_op_e     alu_ctrl;
  logic        shamt_en;
  br_op_e      branch_ctrl;
  logic        jump_ctrl;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  inst_type_e  inst_type;
  logic        illegal;

  modport master (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, alu_ctrl, shamt_en, branch_ctrl,
           jump_ctrl, reg_write, mem_read, mem_write, inst_type, illegal
  );

  modport slave (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, alu_ctrl, shamt_en, branch_ctrl,
           jump_ctrl, reg_write, mem_read, mem_write, inst_type, illegal
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32I(+M) control decoder: opcode/funct3/funct7 in,
// control bundle out. Anything not explicitly recognised is flagged illegal.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output ctrl_bundle_t bundle_o
);

  logic legal;

  // Decode one word; an unrecognised encoding collapses to the illegal bundle.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    bundle_o = '0;
    legal    = 1'b0;

    case (opcode_i)
      OP_R: begin
        bundle_o.inst_type = IT_R;
        bundle_o.reg_write = 1'b1;
        if (funct7_i == F7_BASE) begin
          legal             = 1'b1;
          bundle_o.alu_ctrl = base_alu_op(funct3_i);
        end else if (funct7_i == F7_ALT) begin
          legal             = (funct3_i == 3'b000) || (funct3_i == 3'b101);
          bundle_o.alu_ctrl = (funct3_i == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (EN_MULDIV && (funct7_i == F7_MULDIV)) begin
          // RV32M codes are laid out as MUL + funct3.
          legal             = 1'b1;
          bundle_o.alu_ctrl = alu_op_e'({2'b10, funct3_i});
        end
      end

      OP_IMM: begin
        bundle_o.inst_type = IT_I;
        bundle_o.reg_write = 1'b1;
        bundle_o.alu_ctrl  = base_alu_op(funct3_i);
        case (funct3_i)
          3'b001: begin
            bundle_o.shamt_en = 1'b1;
            legal             = (funct7_i == F7_BASE);
          end
          3'b101: begin
            bundle_o.shamt_en = 1'b1;
            legal             = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
            if (funct7_i == F7_ALT) bundle_o.alu_ctrl = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end

      OP_LOAD: begin
        bundle_o.inst_type = IT_I;
        bundle_o.alu_ctrl  = ALU_ADD;
        bundle_o.mem_read  = 1'b1;
        bundle_o.reg_write = 1'b1;
        legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end

      OP_STORE: begin
        bundle_o.inst_type = IT_S;
        bundle_o.alu_ctrl  = ALU_ADD;
        bundle_o.mem_write = 1'b1;
        legal = (funct3_i <= 3'b010);
      end

      OP_BRANCH: begin
        bundle_o.inst_type = IT_B;
        bundle_o.alu_ctrl  = ALU_SUB;
        legal              = 1'b1;
        case (funct3_i)
          3'b000:  bundle_o.branch_ctrl = BR_BEQ;
          3'b001:  bundle_o.branch_ctrl = BR_BNE;
          3'b100:  bundle_o.branch_ctrl = BR_BLT;
          3'b101:  bundle_o.branch_ctrl = BR_BGE;
          3'b110:  bundle_o.branch_ctrl = BR_BLTU;
          3'b111:  bundle_o.branch_ctrl = BR_BGEU;
          default: legal = 1'b0;
        endcase
      end

      OP_JAL: begin
        bundle_o.inst_type = IT_J;
        bundle_o.jump_ctrl = 1'b1;
        bundle_o.reg_write = 1'b1;
        legal              = 1'b1;
      end

      OP_JALR: begin
        bundle_o.inst_type = IT_I;
        bundle_o.alu_ctrl  = ALU_ADD;
        bundle_o.jump_ctrl = 1'b1;
        bundle_o.reg_write = 1'b1;
        legal              = (funct3_i == 3'b000);
      end

      OP_LUI: begin
        bundle_o.inst_type = IT_U;
        bundle_o.alu_ctrl  = ALU_PASSB;
        bundle_o.reg_write = 1'b1;
        legal              = 1'b1;
      end

      OP_AUIPC: begin
        bundle_o.inst_type = IT_U;
        bundle_o.alu_ctrl  = ALU_ADD;
        bundle_o.reg_write = 1'b1;
        legal              = 1'b1;
      end

      default: legal = 1'b0;
    endcase

    if (!legal) bundle_o = illegal_bundle();
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered control decoder. Decodes on the input side, holds the result in
// an output register and (optionally) one skid entry, counts illegal words
// on acceptance, and supports a flush that empties every stage.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter bit EN_MULDIV = 1'b1,
  parameter bit SKID      = 1'b1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  ctrl_decode_pipe_if.master   bus,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_bundle_t         dec_bundle;
  pipe_entry_t          in_entry;
  pipe_entry_t          out_q, out_d;
  pipe_entry_t          skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [ILL_CNT_W-1:0] ill_count_q, ill_count_d;
  logic                 in_ready;
  logic                 accept;
  logic                 drain;

  ctrl_decode_comb #(
    .EN_MULDIV (EN_MULDIV)
  ) u_decode (
    .opcode_i (bus.in_instr[6:0]),
    .funct3_i (bus.in_instr[14:12]),
    .funct7_i (bus.in_instr[31:25]),
    .bundle_o (dec_bundle)
  );

  // Handshake: with a skid entry in_ready depends only on a flop; without one
  // the single stage can accept whenever it is empty or draining.
  always_comb begin
    in_ready       = SKID ? !skid_valid_q : (!out_valid_q || bus.out_ready);
    accept         = bus.in_valid && in_ready && !flush;
    drain          = out_valid_q && bus.out_ready;
    in_entry.instr = bus.in_instr;
    in_entry.ctrl  = dec_bundle;
  end

  // Pipe occupancy: flush wins, then drain refills from skid or input, then
  // a stalled output diverts a new word into the skid entry. Emptied slots
  // are cleared so idle outputs read as zero.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      out_d        = '0;
      skid_valid_d = 1'b0;
      skid_d       = '0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // A full skid holds in_ready low, so nothing new arrives this cycle.
        out_d        = skid_q;
        skid_valid_d = 1'b0;
        skid_d       = '0;
      end else if (accept) begin
        out_d = in_entry;
      end else begin
        out_valid_d = 1'b0;
        out_d       = '0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_d       = in_entry;
      end else begin
        // Only reachable with SKID: without it, accept while full implies drain.
        skid_valid_d = 1'b1;
        skid_d       = in_entry;
      end
    end
  end

  // Saturating count of illegal words taken in; flush does not clear it.
  always_comb begin
    ill_count_d = ill_count_q;
    if (accept && dec_bundle.illegal && (ill_count_q != '1)) begin
      ill_count_d = ill_count_q + ILL_CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the entry registers are reset too; they are small and this keeps every output defined out of reset.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ill_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      ill_count_q  <= ill_count_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_q.instr;
  assign bus.alu_ctrl    = out_q.ctrl.alu_ctrl;
  assign bus.shamt_en    = out_q.ctrl.shamt_en;
  assign bus.branch_ctrl = out_q.ctrl.branch_ctrl;
  assign bus.jump_ctrl   = out_q.ctrl.jump_ctrl;
  assign bus.reg_write   = out_q.ctrl.reg_write;
  assign bus.mem_read    = out_q.ctrl.mem_read;
  assign bus.mem_write   = out_q.ctrl.mem_write;
  assign bus.inst_type   = out_q.ctrl.inst_type;
  assign bus.illegal     = out_q.ctrl.illegal;
  assign ill_count       = ill_count_q;

endmodule
